// File: rtl/uart_rx.sv
// UART receiver: 16x oversampling, mid-bit sampling, false-start rejection, framing/overrun flags.
// Define UART_RX_PARITY_EN to expect one even-parity bit after the data bits.
module uart_rx #(
    parameter int unsigned CLK_FREQ  = 50_000_000,
    parameter int unsigned BAUD_RATE = 9600,
    parameter int unsigned DATA_BITS = 9
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_busy,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 parity_err
);

    localparam int unsigned TICK_RAW = CLK_FREQ / (BAUD_RATE * 16);
    localparam int unsigned TICK_DIV = (TICK_RAW < 1) ? 1 : TICK_RAW;
    localparam int unsigned TickW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TickW-1:0] TickLast = TickW'(TICK_DIV - 1);
    localparam logic [4:0]       LastBit  = 5'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StWaitIdle
`ifdef UART_RX_PARITY_EN
        , StParity
`endif
    } state_e;

    state_e               state_q, state_d;
    logic                 rx_meta_q, rx_s_q;
    logic [TickW-1:0]     tick_cnt_q, tick_cnt_d;
    logic                 tick;
    logic [3:0]           os_cnt_q, os_cnt_d;
    logic [4:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 done_q, done_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_err_q, overrun_err_d;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad_q, par_bad_d;
    logic                 parity_err_q, parity_err_d;
`endif

    assign tick = (tick_cnt_q == TickLast);

    always_comb begin
        state_d       = state_q;
        tick_cnt_d    = tick ? '0 : tick_cnt_q + TickW'(1);
        os_cnt_d      = os_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        done_d        = 1'b0;
        rx_data_d     = rx_data_q;
        rx_valid_d    = rx_valid_q;
        frame_err_d   = 1'b0;
        overrun_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d     = par_bad_q;
        parity_err_d  = 1'b0;
`endif

        case (state_q)
            StIdle: begin
                if (!rx_s_q) begin
                    // Restart the tick phase so sampling lines up with the falling edge.
                    state_d    = StStart;
                    tick_cnt_d = '0;
                    os_cnt_d   = '0;
                    bit_cnt_d  = '0;
                end
            end
            StStart: begin
                if (tick) begin
                    if (os_cnt_q == 4'd7) begin
                        os_cnt_d = '0;
                        state_d  = rx_s_q ? StIdle : StData;
                    end else begin
                        os_cnt_d = os_cnt_q + 4'd1;
                    end
                end
            end
            StData: begin
                if (tick) begin
                    os_cnt_d = os_cnt_q + 4'd1;
                    if (os_cnt_q == 4'd15) begin
                        shift_d                = shift_q >> 1;
                        shift_d[DATA_BITS-1]   = rx_s_q;
                        if (bit_cnt_q == LastBit) begin
                            bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
                            state_d   = StParity;
`else
                            state_d   = StStop;
`endif
                        end else begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (tick) begin
                    os_cnt_d = os_cnt_q + 4'd1;
                    if (os_cnt_q == 4'd15) begin
                        par_bad_d = ^{rx_s_q, shift_q};
                        state_d   = StStop;
                    end
                end
            end
`endif
            StStop: begin
                if (tick) begin
                    os_cnt_d = os_cnt_q + 4'd1;
                    if (os_cnt_q == 4'd15) begin
                        if (rx_s_q) begin
                            done_d  = 1'b1;
                            state_d = StIdle;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = StWaitIdle;
                        end
                    end
                end
            end
            StWaitIdle: begin
                if (rx_s_q) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

        // Completion runs in IDLE, before the next frame can touch shift_q.
        if (done_q) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
            end else begin
                overrun_err_d = 1'b1;
            end
`ifdef UART_RX_PARITY_EN
            parity_err_d = par_bad_q;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q     <= 1'b1;
            rx_s_q        <= 1'b1;
            state_q       <= StIdle;
            tick_cnt_q    <= '0;
            os_cnt_q      <= '0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            done_q        <= 1'b0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            overrun_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q     <= 1'b0;
            parity_err_q  <= 1'b0;
`endif
        end else begin
            rx_meta_q     <= rx_in;
            rx_s_q        <= rx_meta_q;
            state_q       <= state_d;
            tick_cnt_q    <= tick_cnt_d;
            os_cnt_q      <= os_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            done_q        <= done_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            frame_err_q   <= frame_err_d;
            overrun_err_q <= overrun_err_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q     <= par_bad_d;
            parity_err_q  <= parity_err_d;
`endif
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign rx_busy     = (state_q != StIdle);
    assign frame_err   = frame_err_q;
    assign overrun_err = overrun_err_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err  = parity_err_q;
`else
    assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit; handles UART_RX_PARITY_EN builds too.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_in;
    logic [8:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       rx_busy;
    logic       frame_err;
    logic       overrun_err;
    logic       parity_err;

    int checks = 0;
    int errors = 0;

    int         n_frame = 0;
    int         n_ovr   = 0;
    int         n_par   = 0;
    int         n_vrise = 0;
    logic       valid_prev = 1'b0;
    logic [8:0] last_data = '0;

    int b_frame, b_ovr, b_par, b_vrise;

    uart_rx #(
        .CLK_FREQ (1_600_000),
        .BAUD_RATE(100_000),
        .DATA_BITS(9)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_in      (rx_in),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .rx_busy    (rx_busy),
        .frame_err  (frame_err),
        .overrun_err(overrun_err),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    // Pulse counters and capture of each newly presented word.
    always @(negedge clk) begin
        if (frame_err)   n_frame++;
        if (overrun_err) n_ovr++;
        if (parity_err)  n_par++;
        if (rx_valid && !valid_prev) begin
            n_vrise++;
            last_data = rx_data;
        end
        valid_prev = rx_valid;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        b_frame = n_frame;
        b_ovr   = n_ovr;
        b_par   = n_par;
        b_vrise = n_vrise;
    endtask

    task automatic send(input logic [8:0] data, input logic bad_par, input logic stop_val,
                        input int stop_clks);
        rx_in = 1'b0;
        wait_clks(16);
        for (int i = 0; i < 9; i++) begin
            rx_in = data[i];
            wait_clks(16);
        end
`ifdef UART_RX_PARITY_EN
        rx_in = (^data) ^ bad_par;
        wait_clks(16);
`endif
        rx_in = stop_val;
        wait_clks(stop_clks);
        rx_in = 1'b1;
    endtask

    initial begin
        reset    = 1'b1;
        rx_in    = 1'b1;
        rx_ready = 1'b1;
        wait_clks(3);
        check("reset_outputs",
              {18'd0, rx_data, rx_valid, rx_busy, frame_err, overrun_err, parity_err}, 32'd0);
        reset = 1'b0;
        wait_clks(5);

        // Nominal frame
        snap();
        send(9'h155, 1'b0, 1'b1, 16);
        wait_clks(2);
        check("nominal_valid_rises", n_vrise - b_vrise, 1);
        check("nominal_data", last_data, 9'h155);
        check("nominal_no_frame_err", n_frame - b_frame, 0);
        check("nominal_busy_low", rx_busy, 1'b0);
        check("nominal_valid_consumed", rx_valid, 1'b0);

        // False start
        snap();
        rx_in = 1'b0;
        wait_clks(5);
        check("false_start_busy", rx_busy, 1'b1);
        rx_in = 1'b1;
        wait_clks(20);
        check("false_start_idle", rx_busy, 1'b0);
        check("false_start_no_valid", n_vrise - b_vrise, 0);
        check("false_start_no_flags", (n_frame - b_frame) + (n_ovr - b_ovr) + (n_par - b_par), 0);

        // Framing error with a long break
        snap();
        send(9'h0FF, 1'b0, 1'b0, 32);
        check("frame_err_wait_idle_busy", rx_busy, 1'b1);
        check("frame_err_pulse_once", n_frame - b_frame, 1);
        check("frame_err_no_word", n_vrise - b_vrise, 0);
        check("frame_err_valid_low", rx_valid, 1'b0);
        wait_clks(4);
        check("frame_err_back_idle", rx_busy, 1'b0);
        wait_clks(20);
        check("frame_err_no_retrigger", rx_busy, 1'b0);

        // Overrun
        snap();
        rx_ready = 1'b0;
        send(9'h001, 1'b0, 1'b1, 16);
        send(9'h1A5, 1'b0, 1'b1, 16);
        wait_clks(2);
        check("overrun_valid_held", rx_valid, 1'b1);
        check("overrun_old_data", rx_data, 9'h001);
        check("overrun_pulse_once", n_ovr - b_ovr, 1);
        check("overrun_one_load", n_vrise - b_vrise, 1);
        rx_ready = 1'b1;
        wait_clks(1);
        rx_ready = 1'b0;
        check("overrun_drained", rx_valid, 1'b0);
        rx_ready = 1'b1;
        wait_clks(4);

        // Reset in the middle of a frame
        snap();
        rx_in = 1'b0;
        wait_clks(16);
        for (int i = 0; i < 4; i++) begin
            rx_in = 1'b1;
            wait_clks(16);
        end
        rx_in = 1'b1;
        wait_clks(8);
        check("midframe_busy", rx_busy, 1'b1);
        reset = 1'b1;
        wait_clks(1);
        check("midframe_reset_outputs",
              {18'd0, rx_data, rx_valid, rx_busy, frame_err, overrun_err, parity_err}, 32'd0);
        wait_clks(2);
        reset = 1'b0;
        wait_clks(40);
        check("post_reset_idle", rx_busy, 1'b0);
        send(9'h023, 1'b0, 1'b1, 16);
        wait_clks(2);
        check("post_reset_one_word", n_vrise - b_vrise, 1);
        check("post_reset_data", last_data, 9'h023);
        check("post_reset_no_flags", (n_frame - b_frame) + (n_ovr - b_ovr), 0);

`ifdef UART_RX_PARITY_EN
        snap();
        send(9'h003, 1'b1, 1'b1, 16);
        wait_clks(2);
        check("parity_bad_pulse", n_par - b_par, 1);
        check("parity_bad_still_loaded", n_vrise - b_vrise, 1);
        check("parity_bad_data", last_data, 9'h003);
        snap();
        send(9'h003, 1'b0, 1'b1, 16);
        wait_clks(2);
        check("parity_good_no_pulse", n_par - b_par, 0);
        check("parity_good_loaded", n_vrise - b_vrise, 1);
`else
        check("parity_tied_low", n_par, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
